// File: rtl/dmem_access_unit.sv
// Memory-stage access unit: turns one load/store request (optionally indirect)
// into one or two data-cache transactions, stalling the pipeline until done.
//
// state    | meaning
// IDLE     | waiting for a request; captures it on the same edge it is seen
// IND_READ | fetching the pointer word for an indirect access
// ACCESS   | performing the data read or write
// DONE     | one-cycle completion: rdata_valid (and err on timeout)
module dmem_access_unit #(
    parameter int MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_indirect,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        stall,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, IND_READ, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          byte_q, byte_d;
    logic          write_q, write_d;
    logic          err_q, err_d;

    logic          req;
    logic          at_limit;
    logic [15:0]   load_data;

    assign req      = req_read | req_write;
    assign at_limit = (cnt_q == LIMIT);
    assign rdata    = rdata_q;

    always_comb begin
        if (byte_q) begin
            load_data = {8'h00, (addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
        end else begin
            load_data = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            byte_q  <= byte_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        byte_d          = byte_q;
        write_d         = write_q;
        err_d           = err_q;
        stall           = 1'b0;
        rdata_valid     = 1'b0;
        err             = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = 2'b00;

        case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    byte_d  = req_byte;
                    write_d = req_write;
                    cnt_d   = '0;
                    state_d = req_indirect ? IND_READ : ACCESS;
                end
            end

            IND_READ: begin
                stall           = 1'b1;
                mem_read        = 1'b1;
                mem_address     = {addr_q[15:1], 1'b0};
                mem_byte_enable = 2'b11;
                if (mem_resp) begin
                    addr_d  = mem_rdata;
                    byte_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end else if (at_limit) begin
                    // abandon the access phase entirely on a pointer-fetch timeout
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ACCESS: begin
                stall     = 1'b1;
                mem_read  = ~write_q;
                mem_write = write_q;
                if (byte_q) begin
                    mem_address     = addr_q;
                    mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    mem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
                end else begin
                    mem_address     = {addr_q[15:1], 1'b0};
                    mem_byte_enable = 2'b11;
                    mem_wdata       = wdata_q;
                end
                if (mem_resp) begin
                    rdata_d = write_q ? 16'h0000 : load_data;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (at_limit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                rdata_valid = 1'b1;
                err         = err_q;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_dmem_access_unit;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write, req_byte, req_indirect;
    logic [15:0] req_addr, req_wdata;
    logic        stall, rdata_valid, err, mem_read, mem_write, mem_resp;
    logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic [1:0]  mem_byte_enable;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write), .req_byte(req_byte),
        .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // lat = cycles of strobe before the cache answers; 0 means it never answers
    typedef struct packed {
        logic        rd, wr, by, ind;
        logic [15:0] addr, wdata;
        int          lat1;
        logic [15:0] d1;
        int          lat2;
        logic [15:0] d2;
    } req_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata, rdata;
        logic        err;
        int          cyc;
        int          strobes;
        logic        steady;
        logic        stall_done;
        logic        stall_req;
        logic [15:0] p0_addr;
        logic        p0_wr;
    } res_t;

    typedef struct packed {
        req_t rq;
        res_t ex;
    } vec_t;

    function automatic req_t mkreq(logic rd, logic wr, logic by, logic ind, logic [15:0] addr,
                                   logic [15:0] wdata, int lat1, logic [15:0] d1, int lat2,
                                   logic [15:0] d2);
        req_t r;
        r = '{rd: rd, wr: wr, by: by, ind: ind, addr: addr, wdata: wdata,
              lat1: lat1, d1: d1, lat2: lat2, d2: d2};
        return r;
    endfunction

    function automatic res_t mkexp(logic wr, logic [15:0] addr, logic [1:0] be, logic [15:0] wdata,
                                   logic [15:0] rdat, logic e, int cyc, int strobes);
        res_t x;
        x = '0;
        x.wr = wr; x.addr = addr; x.be = be; x.wdata = wdata; x.rdata = rdat;
        x.err = e; x.cyc = cyc; x.strobes = strobes; x.steady = 1'b1; x.stall_req = 1'b1;
        return x;
    endfunction

    // Transaction-level reference: what the final cache phase looks like and when it ends.
    function automatic res_t model(req_t r);
        res_t        e;
        logic [15:0] a2, d;
        logic        by2;
        int          base, lat;
        e = '0;
        e.steady = 1'b1;
        e.stall_req = 1'b1;
        if (r.ind && r.lat1 == 0) begin
            e.addr = {r.addr[15:1], 1'b0};
            e.be = 2'b11;
            e.err = 1'b1;
            e.strobes = MW;
            e.cyc = MW + 1;
            return e;
        end
        a2   = r.ind ? r.d1 : r.addr;
        by2  = r.ind ? 1'b0 : r.by;
        base = r.ind ? r.lat1 : 0;
        lat  = r.ind ? r.lat2 : r.lat1;
        d    = r.ind ? r.d2 : r.d1;
        e.wr    = r.wr;
        e.addr  = by2 ? a2 : {a2[15:1], 1'b0};
        e.be    = by2 ? (a2[0] ? 2'b10 : 2'b01) : 2'b11;
        e.wdata = by2 ? {r.wdata[7:0], r.wdata[7:0]} : r.wdata;
        if (lat == 0) begin
            e.err = 1'b1;
            e.strobes = base + MW;
            e.cyc = base + MW + 1;
        end else begin
            e.strobes = base + lat;
            e.cyc = base + lat + 1;
            if (r.wr)     e.rdata = 16'h0000;
            else if (by2) e.rdata = a2[0] ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
            else          e.rdata = d;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drives one request from an IDLE cycle and plays the cache, recording what it saw.
    task automatic run_txn(input req_t r, output res_t a);
        int          ph, pc;
        int          lat[2];
        logic [15:0] dat[2];
        logic [35:0] snap, cur;
        a = '0;
        a.cyc = -1;
        a.steady = 1'b1;
        lat[0] = r.lat1; lat[1] = r.lat2;
        dat[0] = r.d1;   dat[1] = r.d2;
        ph = 0; pc = 0; snap = '0;
        @(negedge clk);
        req_read = r.rd; req_write = r.wr; req_byte = r.by; req_indirect = r.ind;
        req_addr = r.addr; req_wdata = r.wdata;
        #1 a.stall_req = stall;
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            mem_resp = 1'b0;
            mem_rdata = 16'($urandom);
            if (rdata_valid) begin
                a.cyc = c; a.rdata = rdata; a.err = err; a.stall_done = stall;
                break;
            end
            if (mem_read | mem_write) begin
                a.strobes++;
                cur = {mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata};
                if (mem_read & mem_write) a.steady = 1'b0;
                if (pc == 0) begin
                    snap = cur;
                    if (ph == 0) begin
                        a.p0_addr = mem_address;
                        a.p0_wr = mem_write;
                    end
                end else if (cur !== snap) begin
                    a.steady = 1'b0;
                end
                a.wr = mem_write; a.addr = mem_address; a.be = mem_byte_enable; a.wdata = mem_wdata;
                pc++;
                if (ph < 2 && lat[ph] != 0 && pc == lat[ph]) begin
                    mem_resp = 1'b1;
                    mem_rdata = dat[ph];
                    ph++;
                    pc = 0;
                end
            end
        end
        req_read = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
        mem_resp = 1'b0;
    endtask

    task automatic check_res(input string tag, input req_t r, input res_t a, input res_t e);
        chk({tag, ".cycle"}, a.cyc, e.cyc);
        if (a.cyc < 0) return;
        chk({tag, ".rdata"}, 32'(a.rdata), 32'(e.rdata));
        chk({tag, ".err"}, 32'(a.err), 32'(e.err));
        chk({tag, ".strobes"}, a.strobes, e.strobes);
        chk({tag, ".addr"}, 32'(a.addr), 32'(e.addr));
        chk({tag, ".be"}, 32'(a.be), 32'(e.be));
        chk({tag, ".dir"}, 32'(a.wr), 32'(e.wr));
        if (e.wr) chk({tag, ".wdata"}, 32'(a.wdata), 32'(e.wdata));
        chk({tag, ".steady"}, 32'(a.steady), 32'(e.steady));
        chk({tag, ".stall_req"}, 32'(a.stall_req), 32'(e.stall_req));
        chk({tag, ".stall_done"}, 32'(a.stall_done), 32'(e.stall_done));
        if (r.ind) begin
            chk({tag, ".ptr_addr"}, 32'(a.p0_addr), 32'({r.addr[15:1], 1'b0}));
            chk({tag, ".ptr_dir"}, 32'(a.p0_wr), 32'(0));
        end
        @(negedge clk);
        chk({tag, ".rdata_hold"}, 32'(rdata), 32'(e.rdata));
        chk({tag, ".idle_quiet"}, 32'({rdata_valid, err, mem_read, mem_write, stall}), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        req_t r;
        res_t a, e;
        int   extra_valid;

        reset = 1'b1;
        req_read = 0; req_write = 0; req_byte = 0; req_indirect = 0;
        req_addr = 0; req_wdata = 0; mem_resp = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.outputs", 32'({stall, rdata_valid, err, mem_read, mem_write, mem_byte_enable}), 32'(0));
        chk("reset.rdata", 32'(rdata), 32'(0));
        chk("reset.mem_bus", 32'({mem_address, mem_wdata}), 32'(0));
        reset = 1'b0;

        // stray cache responses while idle must do nothing
        mem_resp = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_resp.quiet", 32'({rdata_valid, err, mem_read, mem_write, stall}), 32'(0));
        end
        mem_resp = 1'b0;

        //                   rd wr by ind addr     wdata    lat1 d1       lat2 d2
        tbl.push_back('{mkreq(1, 0, 0, 0, 16'h1235, 16'h0000, 3, 16'hBEEF, 0, 16'h0),
                        mkexp(0, 16'h1234, 2'b11, 16'h0, 16'hBEEF, 0, 4, 3)});
        tbl.push_back('{mkreq(1, 0, 1, 0, 16'h2001, 16'h0000, 2, 16'hA55A, 0, 16'h0),
                        mkexp(0, 16'h2001, 2'b10, 16'h0, 16'h00A5, 0, 3, 2)});
        tbl.push_back('{mkreq(1, 0, 1, 0, 16'h2000, 16'h0000, 1, 16'hA55A, 0, 16'h0),
                        mkexp(0, 16'h2000, 2'b01, 16'h0, 16'h005A, 0, 2, 1)});
        tbl.push_back('{mkreq(0, 1, 1, 0, 16'h3003, 16'h12C7, 2, 16'hFFFF, 0, 16'h0),
                        mkexp(1, 16'h3003, 2'b10, 16'hC7C7, 16'h0000, 0, 3, 2)});
        tbl.push_back('{mkreq(1, 0, 0, 1, 16'h4000, 16'h0000, 2, 16'h5002, 1, 16'h7777),
                        mkexp(0, 16'h5002, 2'b11, 16'h0, 16'h7777, 0, 4, 3)});
        tbl.push_back('{mkreq(0, 1, 0, 1, 16'h4000, 16'h1111, 1, 16'h5002, 2, 16'h9999),
                        mkexp(1, 16'h5002, 2'b11, 16'h1111, 16'h0000, 0, 4, 3)});
        tbl.push_back('{mkreq(1, 0, 0, 0, 16'h6000, 16'h0000, 0, 16'h1234, 0, 16'h0),
                        mkexp(0, 16'h6000, 2'b11, 16'h0, 16'h0000, 1, 5, 4)});
        tbl.push_back('{mkreq(1, 0, 0, 0, 16'h6000, 16'h0000, 4, 16'h1357, 0, 16'h0),
                        mkexp(0, 16'h6000, 2'b11, 16'h0, 16'h1357, 0, 5, 4)});
        tbl.push_back('{mkreq(1, 1, 0, 0, 16'h0102, 16'hABCD, 1, 16'h5555, 0, 16'h0),
                        mkexp(1, 16'h0102, 2'b11, 16'hABCD, 16'h0000, 0, 2, 1)});
        tbl.push_back('{mkreq(1, 0, 0, 1, 16'h4445, 16'h0000, 0, 16'h5002, 1, 16'h7777),
                        mkexp(0, 16'h4444, 2'b11, 16'h0, 16'h0000, 1, 5, 4)});
        tbl.push_back('{mkreq(1, 0, 1, 1, 16'h4001, 16'h0000, 1, 16'h5003, 1, 16'hA55A),
                        mkexp(0, 16'h5002, 2'b11, 16'h0, 16'hA55A, 0, 3, 2)});

        foreach (tbl[i]) begin
            run_txn(tbl[i].rq, a);
            check_res($sformatf("vec%0d", i), tbl[i].rq, a, tbl[i].ex);
        end

        // reset while a load is waiting on the cache
        @(negedge clk);
        req_read = 1'b1; req_addr = 16'h0A0A;
        @(posedge clk);
        @(negedge clk);
        req_read = 1'b0;
        chk("rst_mid.strobe_before", 32'(mem_read), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid.strobe_after", 32'({mem_read, mem_write}), 32'(0));
        chk("rst_mid.stall", 32'(stall), 32'(0));
        chk("rst_mid.valid", 32'(rdata_valid), 32'(0));
        extra_valid = 0;
        mem_resp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rdata_valid | mem_read | mem_write) extra_valid++;
        end
        mem_resp = 1'b0;
        chk("rst_mid.no_completion", extra_valid, 0);
        run_txn(tbl[0].rq, a);
        check_res("rst_mid.after", tbl[0].rq, a, tbl[0].ex);

        for (int i = 0; i < 40; i++) begin
            r.wr    = 1'($urandom_range(0, 1));
            r.rd    = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            r.by    = 1'($urandom_range(0, 1));
            r.ind   = ($urandom_range(0, 3) == 0);
            r.addr  = 16'($urandom);
            r.wdata = 16'($urandom);
            r.lat1  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MW));
            r.d1    = 16'($urandom);
            r.lat2  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MW));
            r.d2    = 16'($urandom);
            e = model(r);
            run_txn(r, a);
            check_res($sformatf("rnd%0d", i), r, a, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage responder for the control word's read_memory/write_memory requests.
- Turns one pipeline request (LDR/STR/LDB/STB/LDI/STI) into one or two data-cache transactions on the mem_read/mem_write/mem_resp handshake.
- Stalls the pipeline while the access is in flight and returns aligned load data.
- Sits between the MEM pipeline register and the data cache port.

Parameters:
MAX_WAIT, 64, cycles allowed per cache transaction before abort (≥2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_read  input  1  load request (control word read_memory)
req_write  input  1  store request (control word write_memory)
req_byte  input  1  byte access (LDB/STB)
req_indirect  input  1  indirect access (LDI/STI)
req_addr  input  16  effective address
req_wdata  input  16  store data
stall  output  1  hold pipeline
rdata  output  16  load result, valid with rdata_valid
rdata_valid  output  1  one-cycle completion pulse (loads and stores)
err  output  1  one-cycle timeout pulse, coincident with rdata_valid
mem_read  output  1  cache read strobe
mem_write  output  1  cache write strobe
mem_address  output  16  cache address
mem_wdata  output  16  cache write data
mem_byte_enable  output  2  cache byte lanes
mem_resp  input  1  cache completion
mem_rdata  input  16  cache read data

Behaviour:
- States: IDLE, IND_READ, ACCESS, DONE.
- Reset: state IDLE; wait counter 0; captured registers 0; all outputs 0.
- Reset mid-transaction: next edge returns to IDLE and drops mem_read/mem_write; the aborted access produces no rdata_valid.
- IDLE → capture stage:
  - When req_read|req_write is high, capture addr, wdata, byte, indirect and direction.
  - Both req_read and req_write high: treat as a write.
  - Then go to IND_READ if indirect, else ACCESS.
  - stall = 1 combinationally in IDLE whenever a request is present.
  - Pipeline holds request inputs stable while stall = 1. Inputs are ignored outside IDLE.
- IND_READ:
  - mem_read = 1, mem_address = {addr[15:1],0}, mem_byte_enable = 2'b11.
  - On mem_resp: latch mem_rdata as the new address, force byte = 0, go to ACCESS.
  - stall = 1.
- ACCESS:
  - Word access: mem_address = {addr[15:1],0}, byte_enable = 2'b11, mem_wdata = wdata.
  - Byte access: mem_address = addr, byte_enable = addr[0] ? 2'b10 : 2'b01, mem_wdata = {wdata[7:0], wdata[7:0]}.
  - mem_read = !write, mem_write = write.
  - On mem_resp: register load data and go to DONE.
  - Word load data = mem_rdata. Byte load data = zero-extended selected byte (high byte if addr[0] = 1).
  - stall = 1.
- DONE:
  - rdata_valid = 1, stall = 0, mem strobes 0.
  - rdata holds the result (0 for stores).
  - Unconditional → IDLE. A new request is not sampled until the following cycle.
- Strobes are pure state decodes: held steady across the whole IND_READ/ACCESS state, deasserted the cycle after mem_resp.
- mem_resp in IDLE/DONE: ignored.
- Latency, non-indirect, cache responds in cycle k:
  - Request seen cycle 0.
  - Strobe high cycles 1..k.
  - rdata_valid in cycle k+1.
- Indirect latency: adds one full transaction.
- Timeout:
  - Counter resets on entry to IND_READ/ACCESS and increments each cycle without mem_resp.
  - At count MAX_WAIT-1 without mem_resp: go to DONE with err = 1 and rdata = 0, skipping any remaining phase.
  - mem_resp in the same cycle as the limit wins (normal completion).
- rdata holds its value between completions. err is 0 except in the DONE cycle of an aborted access.

Test Plan:
1. Word load: addr 0x1235, mem_rdata 0xBEEF, resp after 3 cycles → mem_address 0x1234, byte_enable 11, rdata_valid with rdata 0xBEEF in cycle 4, stall low that cycle.
2. Byte load odd: addr 0x2001, mem_rdata 0xA55A → byte_enable 10, rdata 0x00A5. Same test at addr 0x2000 → byte_enable 01, rdata 0x005A.
3. Byte store: addr 0x3003, wdata 0x12C7 → mem_write = 1, mem_wdata 0xC7C7, byte_enable 10, rdata_valid with rdata 0.
4. Indirect load: addr 0x4000, first resp data 0x5002, second resp data 0x7777 → second mem_address 0x5002, rdata 0x7777. Indirect store at the same pointer → second phase mem_write = 1, mem_address 0x5002.
5. Timeout (MAX_WAIT = 4): mem_resp never asserted → strobe high exactly 4 cycles, then err = 1, rdata_valid = 1, rdata 0. Repeat with mem_resp arriving in the 4th cycle → normal completion, err = 0.
6. Reset in ACCESS with mem_read high → next cycle mem_read = 0, stall = 0, no rdata_valid; a subsequent request completes normally.
